rps_match_ctrl: RTL and testbench
=================================

RPS_MATCH_CTRL -- requirements
Module: rps_match_ctrl

Interface
REQ-001 Parameter WIN_TARGET, default 3, round wins needed to take the match (1..15).
REQ-002 Parameter MAX_ROUNDS, default 15, round limit before the match is forced to end (1..255).
REQ-003 Parameter TIMEOUT, default 255, cycles allowed in COLLECT before unmade moves forfeit (1..65535).
REQ-004 One clock; reset is asynchronous and active-high: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-005 start input 1, match start request, sampled only in IDLE.
REQ-006 move1_vld input 1, player 1 move valid; move1 input 2, 00 rock, 01 paper, 10 scissor, 11 invalid; move1_rdy output 1, player 1 move accept.
REQ-007 move2_vld, move2, move2_rdy: same as REQ-006 for player 2.
REQ-008 busy output 1, high in every state except IDLE.
REQ-009 wins1, wins2 output 4 each, round wins per player in the current/last match.
REQ-010 round_cnt output 8, rounds judged in the current/last match.
REQ-011 match_done output 1, single-cycle pulse at match end; match_winner output 2, 00 draw, 01 player 1, 10 player 2, 11 never driven.

Function
REQ-012 FSM states IDLE, COLLECT, JUDGE, DONE; IDLE->COLLECT on start, clearing wins1, wins2, round_cnt, match_winner and timeout counter in the same edge.
REQ-013 In COLLECT, moveN_rdy is high while player N's move for this round is not yet captured; capture on moveN_vld & moveN_rdy; rdy drops the cycle after capture.
REQ-014 Both moves may be captured on the same edge; COLLECT->JUDGE on the edge after both captured flags are set.
REQ-015 Timeout counter increments each COLLECT cycle, clears on entry to COLLECT; on reaching TIMEOUT the state moves to JUDGE with missing moves marked as forfeit.
REQ-016 JUDGE lasts exactly one cycle; outcome: rock beats scissor, scissor beats paper, paper beats rock; equal moves tie.
REQ-017 Invalid move (11) or timeout-missing move is a forfeit: the other player wins the round; both forfeited = tie.
REQ-018 In JUDGE: round_cnt increments by 1; winner's wins counter increments by 1; tie changes no wins counter.
REQ-019 After JUDGE: if updated wins1 or wins2 equals WIN_TARGET, or updated round_cnt equals MAX_ROUNDS, go to DONE, else COLLECT (captured flags cleared).
REQ-020 WIN_TARGET check takes priority over MAX_ROUNDS when both hold on the same round.
REQ-021 DONE lasts one cycle: match_done = 1, match_winner = player with more wins (draw if equal), then IDLE.
REQ-022 wins1, wins2, round_cnt, match_winner hold after DONE until the next start; counters never wrap.
REQ-023 start while busy is ignored; moveN_vld outside COLLECT is ignored (rdy low).
REQ-024 Minimum round latency with moves presented immediately: 2 cycles (COLLECT capture, JUDGE).

Reset
REQ-025 rst asserted at any time, including mid-match, immediately forces IDLE; busy, move1_rdy, move2_rdy, match_done = 0; wins1, wins2 = 0; round_cnt = 0; match_winner = 00; captured flags and timeout counter cleared.
REQ-026 After rst deasserts, no round resumes; a new start is required.

Verification
REQ-027 Defaults, start, player 1 rock, player 2 scissor for 3 rounds, both vld each cycle -> wins1=3, wins2=0, round_cnt=3, match_winner=01, match_done one pulse, 6 cycles after start.
REQ-028 MAX_ROUNDS=4, all rounds tie (paper/paper) -> round_cnt=4, wins 0/0, match_winner=00.
REQ-029 TIMEOUT=10, player 1 moves, player 2 silent -> JUDGE after 10 COLLECT cycles, wins1 increments, move2_rdy high throughout.
REQ-030 Player 1 move 11, player 2 rock -> wins2 increments; both 11 -> tie, round_cnt only increments.
REQ-031 Player 2 presents move 3 cycles after player 1 -> move1_rdy low after capture, player 1 later moves ignored, single judgement.
REQ-032 rst pulsed mid-COLLECT with wins1=2 -> all outputs zero asynchronously, busy=0, start needed to resume.

Source files
------------

// File: rtl/rps_match_ctrl_if.sv
// Handshake and status bundle for the rock-paper-scissors match controller.
// The controller attaches as slave; the driving environment attaches as master.
interface rps_match_ctrl_if;
    logic       start;
    logic       move1_vld;
    logic [1:0] move1;
    logic       move1_rdy;
    logic       move2_vld;
    logic [1:0] move2;
    logic       move2_rdy;
    logic       busy;
    logic [3:0] wins1;
    logic [3:0] wins2;
    logic [7:0] round_cnt;
    logic       match_done;
    logic [1:0] match_winner;

    modport master (
        output start, move1_vld, move1, move2_vld, move2,
        input  move1_rdy, move2_rdy, busy, wins1, wins2, round_cnt, match_done, match_winner
    );

    modport slave (
        input  start, move1_vld, move1, move2_vld, move2,
        output move1_rdy, move2_rdy, busy, wins1, wins2, round_cnt, match_done, match_winner
    );
endinterface

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller: collects one move per player per round,
// judges the round, and ends the match on a win target or a round limit.
module rps_match_ctrl #(
    parameter int unsigned WIN_TARGET = 3,
    parameter int unsigned MAX_ROUNDS = 15,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic              clk,
    input logic              rst,
    rps_match_ctrl_if.slave  bus
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StJudge   = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    localparam logic [1:0] MvRock    = 2'b00;
    localparam logic [1:0] MvPaper   = 2'b01;
    localparam logic [1:0] MvScissor = 2'b10;
    localparam logic [1:0] MvInvalid = 2'b11;

    localparam logic [3:0]  WinTarget = 4'(WIN_TARGET);
    localparam logic [7:0]  MaxRounds = 8'(MAX_ROUNDS);
    localparam logic [15:0] Timeout   = 16'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic        cap1_q, cap1_d, cap2_q, cap2_d;
    logic [1:0]  move1_q, move1_d, move2_q, move2_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [3:0]  wins1_q, wins1_d, wins2_q, wins2_d;
    logic [7:0]  round_cnt_q, round_cnt_d;
    logic [1:0]  winner_q, winner_d;

    logic rdy1, rdy2;
    logic forfeit1, forfeit2, beats12, beats21, p1_win, p2_win;

    assign rdy1 = (state_q == StCollect) && !cap1_q;
    assign rdy2 = (state_q == StCollect) && !cap2_q;

    // A missing (timed-out) move is treated exactly like an invalid one.
    always_comb begin
        forfeit1 = !cap1_q || (move1_q == MvInvalid);
        forfeit2 = !cap2_q || (move2_q == MvInvalid);
        beats12  = ((move1_q == MvRock)    && (move2_q == MvScissor)) ||
                   ((move1_q == MvScissor) && (move2_q == MvPaper))   ||
                   ((move1_q == MvPaper)   && (move2_q == MvRock));
        beats21  = ((move2_q == MvRock)    && (move1_q == MvScissor)) ||
                   ((move2_q == MvScissor) && (move1_q == MvPaper))   ||
                   ((move2_q == MvPaper)   && (move1_q == MvRock));
        p1_win   = !forfeit1 && (forfeit2 || beats12);
        p2_win   = !forfeit2 && (forfeit1 || beats21);
    end

    always_comb begin
        state_d     = state_q;
        cap1_d      = cap1_q;
        cap2_d      = cap2_q;
        move1_d     = move1_q;
        move2_d     = move2_q;
        to_cnt_d    = to_cnt_q;
        wins1_d     = wins1_q;
        wins2_d     = wins2_q;
        round_cnt_d = round_cnt_q;
        winner_d    = winner_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d     = StCollect;
                    cap1_d      = 1'b0;
                    cap2_d      = 1'b0;
                    to_cnt_d    = '0;
                    wins1_d     = '0;
                    wins2_d     = '0;
                    round_cnt_d = '0;
                    winner_d    = 2'b00;
                end
            end
            StCollect: begin
                if (rdy1 && bus.move1_vld) begin
                    cap1_d  = 1'b1;
                    move1_d = bus.move1;
                end
                if (rdy2 && bus.move2_vld) begin
                    cap2_d  = 1'b1;
                    move2_d = bus.move2;
                end
                to_cnt_d = to_cnt_q + 16'd1;
                // Judge as soon as both moves are in hand, giving a 2-cycle minimum round.
                if ((cap1_d && cap2_d) || (to_cnt_d == Timeout)) begin
                    state_d = StJudge;
                end
            end
            StJudge: begin
                if (round_cnt_q != 8'hFF) round_cnt_d = round_cnt_q + 8'd1;
                if (p1_win && (wins1_q != 4'hF)) wins1_d = wins1_q + 4'd1;
                if (p2_win && (wins2_q != 4'hF)) wins2_d = wins2_q + 4'd1;
                cap1_d   = 1'b0;
                cap2_d   = 1'b0;
                to_cnt_d = '0;
                if ((wins1_d == WinTarget) || (wins2_d == WinTarget) ||
                    (round_cnt_d == MaxRounds)) begin
                    state_d = StDone;
                    if (wins1_d > wins2_d) begin
                        winner_d = 2'b01;
                    end else if (wins2_d > wins1_d) begin
                        winner_d = 2'b10;
                    end else begin
                        winner_d = 2'b00;
                    end
                end else begin
                    state_d = StCollect;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cap1_q      <= 1'b0;
            cap2_q      <= 1'b0;
            move1_q     <= 2'b00;
            move2_q     <= 2'b00;
            to_cnt_q    <= '0;
            wins1_q     <= '0;
            wins2_q     <= '0;
            round_cnt_q <= '0;
            winner_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            cap1_q      <= cap1_d;
            cap2_q      <= cap2_d;
            move1_q     <= move1_d;
            move2_q     <= move2_d;
            to_cnt_q    <= to_cnt_d;
            wins1_q     <= wins1_d;
            wins2_q     <= wins2_d;
            round_cnt_q <= round_cnt_d;
            winner_q    <= winner_d;
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.move1_rdy    = rdy1;
    assign bus.move2_rdy    = rdy2;
    assign bus.wins1        = wins1_q;
    assign bus.wins2        = wins2_q;
    assign bus.round_cnt    = round_cnt_q;
    assign bus.match_done   = (state_q == StDone);
    assign bus.match_winner = winner_q;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Bench for rps_match_ctrl: directed match scenarios plus random play, all checked
// every cycle against a behavioural match model.
module tb_rps_match_ctrl;

    localparam int WT = 3;
    localparam int MR = 4;
    localparam int TO = 10;

    localparam int PIdle    = 0;
    localparam int PCollect = 1;
    localparam int PJudge   = 2;
    localparam int PDone    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    rps_match_ctrl_if bus ();

    rps_match_ctrl #(
        .WIN_TARGET (WT),
        .MAX_ROUNDS (MR),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural match model
    int m_phase, got1, got2, mv1, mv2, waited, w1, w2, rounds, winner;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int round_result(int g1, int a, int g2, int b);
        bit f1, f2;
        int d;
        f1 = (g1 == 0) || (a == 3);
        f2 = (g2 == 0) || (b == 3);
        if (f1 && f2) return 0;
        if (f1) return 2;
        if (f2) return 1;
        d = (a + 3 - b) % 3;  // 1: player 1 beats player 2 in the rock/paper/scissor cycle
        if (d == 0) return 0;
        return (d == 1) ? 1 : 2;
    endfunction

    task automatic model_reset();
        m_phase = PIdle; got1 = 0; got2 = 0; mv1 = 0; mv2 = 0;
        waited = 0; w1 = 0; w2 = 0; rounds = 0; winner = 0;
    endtask

    task automatic model_step(input int s, input int v1, input int a, input int v2, input int b);
        int r;
        case (m_phase)
            PIdle: if (s != 0) begin
                m_phase = PCollect; got1 = 0; got2 = 0; waited = 0;
                w1 = 0; w2 = 0; rounds = 0; winner = 0;
            end
            PCollect: begin
                if (got1 == 0 && v1 != 0) begin got1 = 1; mv1 = a; end
                if (got2 == 0 && v2 != 0) begin got2 = 1; mv2 = b; end
                waited++;
                if ((got1 != 0 && got2 != 0) || waited == TO) m_phase = PJudge;
            end
            PJudge: begin
                r = round_result(got1, mv1, got2, mv2);
                rounds++;
                if (r == 1) w1++;
                if (r == 2) w2++;
                got1 = 0; got2 = 0; waited = 0;
                if (w1 == WT || w2 == WT || rounds == MR) begin
                    m_phase = PDone;
                    winner = (w1 > w2) ? 1 : (w2 > w1) ? 2 : 0;
                end else begin
                    m_phase = PCollect;
                end
            end
            default: m_phase = PIdle;
        endcase
    endtask

    task automatic compare();
        chk("busy",   int'(bus.busy),       int'(m_phase != PIdle));
        chk("rdy1",   int'(bus.move1_rdy),  int'(m_phase == PCollect && got1 == 0));
        chk("rdy2",   int'(bus.move2_rdy),  int'(m_phase == PCollect && got2 == 0));
        chk("wins1",  int'(bus.wins1),      w1);
        chk("wins2",  int'(bus.wins2),      w2);
        chk("rounds", int'(bus.round_cnt),  rounds);
        chk("done",   int'(bus.match_done), int'(m_phase == PDone));
        chk("winner", int'(bus.match_winner), winner);
    endtask

    task automatic tick(input int s, input int v1, input int a, input int v2, input int b);
        bus.start     = 1'(s);
        bus.move1_vld = 1'(v1);
        bus.move1     = 2'(a);
        bus.move2_vld = 1'(v2);
        bus.move2     = 2'(b);
        @(posedge clk);
        if (!rst) model_step(s, v1, a, v2, b);
        @(negedge clk);
        compare();
    endtask

    // Called at a negedge; reset lands mid-cycle to exercise the asynchronous path.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_busy",   int'(bus.busy), 0);
        chk("rst_rdy1",   int'(bus.move1_rdy), 0);
        chk("rst_rdy2",   int'(bus.move2_rdy), 0);
        chk("rst_wins1",  int'(bus.wins1), 0);
        chk("rst_rounds", int'(bus.round_cnt), 0);
        chk("rst_winner", int'(bus.match_winner), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare();
    endtask

    initial begin
        int n, k, thr1, thr2;
        bus.start = 1'b0; bus.move1_vld = 1'b0; bus.move1 = 2'b00;
        bus.move2_vld = 1'b0; bus.move2 = 2'b00;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare();

        // Rock vs scissor, three straight wins for player 1
        tick(1, 1, 0, 1, 2);
        n = 0;
        while (!bus.match_done && n < 20) begin
            tick(0, 1, 0, 1, 2);
            n++;
        end
        chk("rrr_latency", n, 6);
        chk("rrr_wins1", int'(bus.wins1), 3);
        chk("rrr_wins2", int'(bus.wins2), 0);
        chk("rrr_rounds", int'(bus.round_cnt), 3);
        chk("rrr_winner", int'(bus.match_winner), 1);
        tick(1, 1, 0, 1, 2);  // start during DONE is ignored
        chk("rrr_pulse_gone", int'(bus.match_done), 0);
        chk("rrr_idle", int'(bus.busy), 0);
        chk("rrr_hold_wins1", int'(bus.wins1), 3);

        // All ties until the round limit
        tick(1, 0, 0, 0, 0);
        chk("tie_winner_cleared", int'(bus.match_winner), 0);
        n = 0;
        while (!bus.match_done && n < 30) begin
            tick(0, 1, 1, 1, 1);
            n++;
        end
        chk("tie_rounds", int'(bus.round_cnt), 4);
        chk("tie_wins1", int'(bus.wins1), 0);
        chk("tie_wins2", int'(bus.wins2), 0);
        chk("tie_winner", int'(bus.match_winner), 0);
        tick(0, 0, 0, 0, 0);

        // Player 2 silent: timeout forfeits their move
        tick(1, 0, 0, 0, 0);
        k = 0;
        while (bus.move2_rdy && k < 40) begin
            k++;
            tick(0, int'(k == 1), 0, 0, 0);
        end
        chk("timeout_cycles", k, 10);
        tick(0, 0, 0, 0, 0);
        chk("timeout_wins1", int'(bus.wins1), 1);
        chk("timeout_wins2", int'(bus.wins2), 0);

        // Invalid moves
        do_reset();
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 3, 1, 0);
        tick(0, 0, 0, 0, 0);
        chk("inv_p1_wins2", int'(bus.wins2), 1);
        tick(0, 1, 3, 1, 3);
        tick(0, 0, 0, 0, 0);
        chk("inv_both_rounds", int'(bus.round_cnt), 2);
        chk("inv_both_wins1", int'(bus.wins1), 0);
        chk("inv_both_wins2", int'(bus.wins2), 1);

        // Player 2 late; player 1's later moves must not replace the captured paper
        do_reset();
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        chk("late_rdy1_low", int'(bus.move1_rdy), 0);
        tick(0, 1, 2, 0, 0);
        tick(0, 1, 2, 0, 0);
        tick(0, 1, 2, 1, 0);
        tick(0, 1, 2, 0, 0);
        chk("late_wins1", int'(bus.wins1), 1);
        chk("late_rounds", int'(bus.round_cnt), 1);

        // Reset mid-COLLECT with wins1=2, then no resume without start
        do_reset();
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(0, 1, 0, 1, 2);
            tick(0, 0, 0, 0, 0);
        end
        tick(0, 0, 0, 0, 0);
        chk("mid_wins1", int'(bus.wins1), 2);
        do_reset();
        tick(0, 1, 0, 1, 2);
        chk("mid_no_resume", int'(bus.busy), 0);

        // Random play
        thr1 = 12; thr2 = 12;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                thr1 = int'($urandom_range(1, 15));
                thr2 = int'($urandom_range(1, 15));
            end
            if ($urandom_range(0, 599) == 0) do_reset();
            tick(int'($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15) < thr1), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15) < thr2), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
